// File: rtl/unsigned_divider_seq_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM state encoding
// and the default operand width.
package unsigned_divider_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unsigned_divider_seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// try to subtract the divisor, and keep the difference only if it is non-negative.
module unsigned_divider_seq_div_step
  import unsigned_divider_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Trial subtraction; the borrow bit decides restore versus keep.
  // The partial remainder always stays below the divisor, so once the trial
  // fails the shifted value also fits in WIDTH bits and its top bit can be dropped.
  always_comb begin
    shifted_s = {rem_in, bit_in};
    trial_s   = shifted_s - {1'b0, divisor};
    q_bit     = ~trial_s[WIDTH];
    if (q_bit) begin
      rem_out = trial_s[WIDTH-1:0];
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/unsigned_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock under a
// start/done handshake, with registered results and a divide-by-zero flag.
module unsigned_divider_seq
  import unsigned_divider_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  q_r, q_n;
  logic [WIDTH-1:0]  r_r, r_n;
  logic [WIDTH-1:0]  dvs_r, dvs_n;
  logic [CNT_W-1:0]  cnt_r, cnt_n;
  logic [WIDTH-1:0]  quo_n, rem_n;
  logic              busy_n, done_n, dbz_n;
  logic [WIDTH-1:0]  step_rem_s;
  logic              step_bit_s;

  unsigned_divider_seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_r),
    .bit_in  (q_r[WIDTH-1]),
    .divisor (dvs_r),
    .rem_out (step_rem_s),
    .q_bit   (step_bit_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    r_n     = r_r;
    dvs_n   = dvs_r;
    cnt_n   = cnt_r;
    quo_n   = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          if (divisor == {WIDTH{1'b0}}) begin
            state_n = S_DONE;
            quo_n   = {WIDTH{1'b1}};
            rem_n   = dividend;
            dbz_n   = 1'b1;
            done_n  = 1'b1;
          end else begin
            state_n = S_CALC;
            q_n     = dividend;
            r_n     = {WIDTH{1'b0}};
            dvs_n   = divisor;
            cnt_n   = CNT_W'(WIDTH - 1);
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_CALC: begin
        q_n = {q_r[WIDTH-2:0], step_bit_s};
        r_n = step_rem_s;
        // Results are published on the same edge that enters DONE.
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_n = S_DONE;
          quo_n   = q_n;
          rem_n   = r_n;
          dbz_n   = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      q_r         <= {WIDTH{1'b0}};
      r_r         <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state_r     <= state_n;
      q_r         <= q_n;
      r_r         <= r_n;
      dvs_r       <= dvs_n;
      cnt_r       <= cnt_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule

// File: tb/tb_unsigned_divider_seq.sv
// Scoreboard bench for unsigned_divider_seq (WIDTH=4): directed cases, an
// exhaustive operand sweep and randomized traffic against an arithmetic model.
module tb_unsigned_divider_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_at;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           acc_cyc = 1 << 30;
  int           end_cyc = -10;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] held_q = '0, held_r = '0;
  logic         held_dbz = 1'b0;
  logic         prev_done = 1'b0;

  unsigned_divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
    end
  endtask

  // Model: a request is taken only if the block is idle when start is sampled.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    bit   accept;
    int   n;
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    accept   = (cyc > end_cyc);
    n        = cyc + 1;
    @(posedge clk);
    if (accept) begin
      if (b == 0) begin
        e.q = {W{1'b1}}; e.r = a; e.dbz = 1'b1; e.done_at = n;
      end else begin
        e.q = W'(int'(a) / int'(b)); e.r = W'(int'(a) % int'(b));
        e.dbz = 1'b0; e.done_at = n + W;
      end
      sb.push_back(e);
      acc_cyc = n;
      end_cyc = e.done_at;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc <= end_cyc) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_quotient"}, quotient, 0);
    chk({nm, "_remainder"}, remainder, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_dbz"}, div_by_zero, 0);
  endtask

  // Monitor: busy against the model window, results against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, (cyc >= acc_cyc && cyc <= end_cyc) ? 1 : 0);
      if (done) begin
        chk("done_single_pulse", prev_done, 0);
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_done at cycle %0d: got done=1, expected done=0", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_at);
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          held_q = e.q; held_r = e.r; held_dbz = e.dbz;
        end
      end else begin
        chk("held_quotient", quotient, held_q);
        chk("held_remainder", remainder, held_r);
        chk("held_dbz", div_by_zero, held_dbz);
        if (sb.size() > 0 && cyc > sb[0].done_at) begin
          n_vec++; n_err++;
          $display("FAIL missing_done at cycle %0d: got done=0, expected done=1 at cycle %0d",
                   cyc, sb[0].done_at);
          void'(sb.pop_front());
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    do_start(4'd13, 4'd3);
    wait_idle();
    do_start(4'd3, 4'd9);
    wait_idle();
    do_start(4'd15, 4'd1);
    wait_idle();
    do_start(4'd7, 4'd0);
    wait_idle();

    // Second request lands while busy and must be dropped.
    do_start(4'd13, 4'd3);
    idle(1);
    do_start(4'd8, 4'd2);
    wait_idle();
    do_start(4'd8, 4'd2);
    wait_idle();

    // Reset during the second CALC cycle discards the operation.
    idle(1);
    do_start(4'd13, 4'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midcalc_reset");
    sb.delete();
    end_cyc = -10; acc_cyc = 1 << 30;
    held_q = '0; held_r = '0; held_dbz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    do_start(4'd9, 4'd4);
    wait_idle();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_start(a[W-1:0], b[W-1:0]);
        wait_idle();
      end
    end

    repeat (80) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_start(ra, rb);
      idle($urandom_range(0, 6));
    end

    wait_idle();
    idle(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
